// File: rtl/rule_infer.sv
`default_nettype none
// ============================================================================
//  Module   : rule_infer
//  Purpose  : Infers an elementary (radius-1, binary) cellular-automaton rule
//             from consecutive 20-cell generations on a periodic ring. Each
//             generation pair yields 20 (neighbourhood, next-value)
//             observations that fill in rule bits. A contradiction (either
//             against an already learned bit, or between two cells of the
//             same pair) latches a sticky conflict flag.
//  Ports    : clk       - clock, rising edge
//             res       - asynchronous active-low reset
//             in_valid  - in_state carries a generation this cycle
//             in_state  - 20-cell generation, bit p = cell p
//             restart   - synchronous clear of all learned knowledge
//             rule      - learned rule bits (bit k = next value for index k)
//             known     - bit k set once rule[k] has been observed
//             conflict  - sticky contradiction flag
//             done      - all eight rule bits known and no conflict
//             pair_cnt  - generation pairs processed, saturating at 255
//  Revision : 1.0  initial release
// ============================================================================
module rule_infer (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    input  logic [19:0] in_state,
    input  logic        restart,
    output logic [7:0]  rule,
    output logic [7:0]  known,
    output logic        conflict,
    output logic        done,
    output logic [7:0]  pair_cnt
);

    localparam int unsigned c_NCELLS = 20;

    localparam logic [1:0] c_IDLE  = 2'd0;  // no previous generation held
    localparam logic [1:0] c_TRACK = 2'd1;  // previous generation held
    localparam logic [1:0] c_FAULT = 2'd2;  // contradiction found, frozen

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_NCELLS-1:0] r_prev;
    logic [7:0]          r_rule;
    logic [7:0]          r_known;
    logic [7:0]          r_cnt;
    logic                r_conflict;

    logic [2:0]          w_idx [c_NCELLS];
    logic [7:0]          w_seen0;
    logic [7:0]          w_seen1;
    logic [7:0]          w_seen;
    logic [7:0]          w_clash;
    logic                w_pair_bad;

    logic                w_capture;
    logic                w_learn;
    logic                w_commit;
    logic                w_flag;

    // Neighbourhood index per cell: {left, centre, right}, where the left
    // neighbour is the next-higher cell and the ring wraps at both ends.
    generate
        for (genvar p = 0; p < c_NCELLS; p++) begin : g_cell
            assign w_idx[p] = {r_prev[(p + 1) % c_NCELLS],
                               r_prev[p],
                               r_prev[(p + c_NCELLS - 1) % c_NCELLS]};
        end
    endgenerate

    // Collapse the 20 observations into "index k was seen with value 0" and
    // "index k was seen with value 1". Seeing both within one pair is a
    // contradiction regardless of what was learned before.
    always_comb begin
        w_seen0 = 8'h00;
        w_seen1 = 8'h00;
        for (int p = 0; p < c_NCELLS; p++) begin
            if (in_state[p]) begin
                w_seen1[w_idx[p]] = 1'b1;
            end else begin
                w_seen0[w_idx[p]] = 1'b1;
            end
        end
    end

    assign w_seen     = w_seen0 | w_seen1;
    assign w_clash    = (w_seen0 & w_seen1)
                      | (r_known & w_seen1 & ~r_rule)
                      | (r_known & w_seen0 &  r_rule);
    assign w_pair_bad = |w_clash;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        if (restart) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (in_valid) w_next_state = c_TRACK;
                c_TRACK: if (in_valid && w_pair_bad) w_next_state = c_FAULT;
                c_FAULT: w_next_state = c_FAULT;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    // ---------------- FSM: output / control decode ----------------
    always_comb begin
        w_capture = 1'b0;
        w_learn   = 1'b0;
        if (!restart && in_valid) begin
            w_capture = (r_state == c_IDLE);
            w_learn   = (r_state == c_TRACK);
        end
        // A bad pair leaves rule/known untouched but still counts.
        w_commit = w_learn & ~w_pair_bad;
        w_flag   = w_learn &  w_pair_bad;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_prev     <= '0;
            r_rule     <= 8'h00;
            r_known    <= 8'h00;
            r_cnt      <= 8'h00;
            r_conflict <= 1'b0;
        end else if (restart) begin
            r_prev     <= '0;
            r_rule     <= 8'h00;
            r_known    <= 8'h00;
            r_cnt      <= 8'h00;
            r_conflict <= 1'b0;
        end else begin
            if (w_capture || w_learn) begin
                r_prev <= in_state;
            end
            if (w_learn && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_commit) begin
                // Unknown rule bits are always zero, so OR-ing in the newly
                // observed ones fills them without disturbing learned bits.
                r_known <= r_known | w_seen;
                r_rule  <= r_rule | (w_seen1 & ~r_known);
            end
            if (w_flag) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign rule     = r_rule;
    assign known    = r_known;
    assign conflict = r_conflict;
    assign done     = (r_known == 8'hFF) && !r_conflict;
    assign pair_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rule_infer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rule_infer
//  Purpose  : Self-checking bench for rule_infer. A behavioural reference
//             model evaluates each observation one at a time; expected
//             outputs are queued when a step is driven and compared after
//             the clock edge that should reflect it.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_rule_infer;

    logic        clk;
    logic        res;
    logic        in_valid;
    logic [19:0] in_state;
    logic        restart;
    logic [7:0]  rule;
    logic [7:0]  known;
    logic        conflict;
    logic        done;
    logic [7:0]  pair_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] rule;
        logic [7:0] known;
        logic       conf;
        logic       done;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb [$];

    // reference model state: 0 idle, 1 track, 2 fault
    int          m_state;
    logic [19:0] m_prev;
    logic [7:0]  m_rule;
    logic [7:0]  m_known;
    logic        m_conf;
    logic [7:0]  m_cnt;

    rule_infer dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .in_state (in_state),
        .restart  (restart),
        .rule     (rule),
        .known    (known),
        .conflict (conflict),
        .done     (done),
        .pair_cnt (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0;
        m_prev  = '0;
        m_rule  = 8'h00;
        m_known = 8'h00;
        m_conf  = 1'b0;
        m_cnt   = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic [19:0] d, input logic rs);
        logic [7:0] tr;
        logic [7:0] tk;
        logic [2:0] k;
        logic       clash;
        if (rs) begin
            model_clear();
        end else if (v) begin
            if (m_state == 0) begin
                m_prev  = d;
                m_state = 1;
            end else if (m_state == 1) begin
                tr = m_rule;
                tk = m_known;
                clash = 1'b0;
                for (int p = 0; p < 20; p++) begin
                    k = {m_prev[(p + 1) % 20], m_prev[p], m_prev[(p + 19) % 20]};
                    if (tk[k]) begin
                        if (tr[k] != d[p]) clash = 1'b1;
                    end else begin
                        tk[k] = 1'b1;
                        tr[k] = d[p];
                    end
                end
                if (clash) begin
                    m_conf  = 1'b1;
                    m_state = 2;
                end else begin
                    m_rule  = tr;
                    m_known = tk;
                end
                m_prev = d;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
        end
    endtask

    function automatic logic [19:0] ca_step(input logic [7:0] r, input logic [19:0] s);
        logic [19:0] n;
        logic [2:0]  k;
        for (int p = 0; p < 20; p++) begin
            k = {s[(p + 1) % 20], s[p], s[(p + 19) % 20]};
            n[p] = r[k];
        end
        return n;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".rule"},     rule,              e.rule);
        chk({tag, ".known"},    known,             e.known);
        chk({tag, ".conflict"}, {7'd0, conflict},  {7'd0, e.conf});
        chk({tag, ".done"},     {7'd0, done},      {7'd0, e.done});
        chk({tag, ".pair_cnt"}, pair_cnt,          e.cnt);
    endtask

    task automatic step(input string tag, input logic v, input logic [19:0] d, input logic rs);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_state = d;
        restart  = rs;
        model_step(v, d, rs);
        e.rule  = m_rule;
        e.known = m_known;
        e.conf  = m_conf;
        e.done  = (m_known == 8'hFF) && !m_conf;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
        in_state = '0;
    endtask

    initial begin
        logic [19:0] s;
        int          gens;
        res      = 1'b0;
        in_valid = 1'b0;
        in_state = '0;
        restart  = 1'b0;
        model_clear();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rule", rule, 8'h00);
        chk("rst.known", known, 8'h00);
        chk("rst.conflict", {7'd0, conflict}, 8'd0);
        chk("rst.done", {7'd0, done}, 8'd0);
        chk("rst.pair_cnt", pair_cnt, 8'h00);
        @(negedge clk);
        res = 1'b1;

        // single-particle step
        step("sp0", 1'b1, 20'h00001, 1'b0);
        step("sp1", 1'b1, 20'h80000, 1'b0);
        chk("sp.known", known, 8'h17);
        chk("sp.rule", rule, 8'h10);
        chk("sp.conflict", {7'd0, conflict}, 8'd0);
        chk("sp.cnt", pair_cnt, 8'd1);

        // contradiction against learned bit, then frozen in fault
        step("ct0", 1'b1, 20'h00001, 1'b0);
        chk("ct.conflict", {7'd0, conflict}, 8'd1);
        chk("ct.rule", rule, 8'h10);
        chk("ct.known", known, 8'h17);
        chk("ct.cnt", pair_cnt, 8'd2);
        step("ct1", 1'b1, 20'h00000, 1'b0);
        chk("ct.hold_cnt", pair_cnt, 8'd2);
        step("ct_rst", 1'b0, 20'h00000, 1'b1);

        // intra-pair contradiction
        step("ip0", 1'b1, 20'h00000, 1'b0);
        step("ip1", 1'b1, 20'h00001, 1'b0);
        chk("ip.conflict", {7'd0, conflict}, 8'd1);
        chk("ip.known", known, 8'h00);
        chk("ip.done", {7'd0, done}, 8'd0);

        // full learning of rule 184, back-to-back
        for (int tr = 0; tr < 10; tr++) begin
            step("fl_rst", 1'b0, 20'h00000, 1'b1);
            s = 20'($urandom);
            step("fl_seed", 1'b1, s, 1'b0);
            gens = 0;
            while ((gens < 12 || m_known != 8'hFF) && gens < 40) begin
                s = ca_step(8'hB8, s);
                step("fl", 1'b1, s, 1'b0);
                gens++;
            end
            if (m_known == 8'hFF) break;
        end
        chk("fl.rule", rule, 8'hB8);
        chk("fl.known", known, 8'hFF);
        chk("fl.done", {7'd0, done}, 8'd1);
        chk("fl.conflict", {7'd0, conflict}, 8'd0);
        s = ca_step(8'hB8, s);
        step("fl_more", 1'b1, s, 1'b0);
        chk("fl.rule_hold", rule, 8'hB8);

        // restart wins over in_valid; sample discarded
        step("pr0", 1'b1, 20'h5A5A5, 1'b1);
        chk("pr.rule", rule, 8'h00);
        chk("pr.cnt", pair_cnt, 8'd0);
        step("pr1", 1'b1, 20'h00001, 1'b0);
        chk("pr.capture_cnt", pair_cnt, 8'd0);
        step("pr2", 1'b1, 20'h80000, 1'b0);
        chk("pr.known", known, 8'h17);

        // asynchronous reset between samples
        idle();
        @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        model_clear();
        chk("ar.rule", rule, 8'h00);
        chk("ar.known", known, 8'h00);
        chk("ar.cnt", pair_cnt, 8'h00);
        @(negedge clk);
        res = 1'b1;
        step("ar0", 1'b1, 20'h00001, 1'b0);
        chk("ar.first_cnt", pair_cnt, 8'd0);
        step("ar1", 1'b1, 20'h80000, 1'b0);
        chk("ar.second_cnt", pair_cnt, 8'd1);

        // saturation
        step("sat_rst", 1'b0, 20'h00000, 1'b1);
        step("sat0", 1'b1, 20'h00000, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step("sat", 1'b1, 20'h00000, 1'b0);
        end
        chk("sat.cnt", pair_cnt, 8'd255);
        step("sat_more", 1'b1, 20'h00000, 1'b0);
        chk("sat.hold", pair_cnt, 8'd255);
        idle();

        if (sb.size() != 0) chk("sb.leftover", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rule_infer.md
RULE_INFER -- requirements
Module: rule_infer

Interface
REQ-001 The port list SHALL be exactly as below; the clock and reset are named as in the cellular-automaton step block.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 res  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_state carries one automaton generation this cycle.
REQ-005 in_state  input  20  one 20-cell generation, periodic ring.
REQ-006 restart  input  1  synchronous pulse; clears all learned knowledge.
REQ-007 rule  output  8  inferred rule bits; bit k is the next-cell value for neighbourhood k.
REQ-008 known  output  8  bit k is set once rule[k] has been observed.
REQ-009 conflict  output  1  sticky flag: the observations contradict any elementary rule.
REQ-010 done  output  1  high when known equals 8'hFF and conflict is low.
REQ-011 pair_cnt  output  8  number of generation pairs processed; saturates at 255.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE (no previous generation held), TRACK (previous generation held) and FAULT (conflict found).
REQ-013 IDLE + in_valid: in_state is stored in prev and the FSM goes to TRACK; rule, known and pair_cnt do not change.
REQ-014 TRACK + in_valid: each cell p (0..19) SHALL be evaluated as one observation.
- Neighbourhood index k = {prev[p+1], prev[p], prev[p-1]}.
- Index wraps periodically: p=0 uses prev[19] as its right neighbour; p=19 uses prev[0] as its left neighbour.
- Observed next value = in_state[p].
REQ-015 Per observation (k, v):
- If known[k] was 0, set known[k] and set rule[k] = v.
- If known[k] was 1 and rule[k] differs from v, set conflict.
REQ-016 A conflict SHALL also be flagged when two cells in the same pair share index k but have different v, including when known[k] was 0 before the pair.
REQ-017 On each TRACK update, prev SHALL be loaded with in_state and pair_cnt SHALL increment, saturating at 255.
REQ-018 When a pair raises conflict:
- The FSM SHALL go to FAULT.
- rule and known SHALL hold their values from before that pair.
- pair_cnt SHALL still increment for that pair.
REQ-019 In FAULT, in_valid SHALL be ignored; all outputs hold until restart or reset.
REQ-020 Latency: rule, known, conflict, done and pair_cnt SHALL reflect a sample on the rising edge that follows the cycle in which in_valid is high (one cycle).
REQ-021 restart, from any state: on the next edge, rule, known, conflict and pair_cnt SHALL become 0 and the FSM SHALL go to IDLE.
REQ-022 restart and in_valid asserted in the same cycle: restart SHALL win and the sample SHALL be discarded.
REQ-023 Once done is high, further consistent pairs SHALL leave rule and known unchanged and SHALL keep incrementing pair_cnt.
REQ-024 The block SHALL be back-to-back capable: in_valid may be high every cycle.

Reset
REQ-025 While res is 0, the block SHALL hold: rule=0, known=0, conflict=0, done=0, pair_cnt=0, prev=0, FSM=IDLE.
REQ-026 Reset asserted mid-stream SHALL discard prev and all learned bits immediately, without waiting for a clock edge.
REQ-027 After reset is released, the first in_valid SHALL be treated as an IDLE capture.

Verification
REQ-028 Single-particle step: feed 20'h00001 then 20'h80000 -> known=8'h17, rule=8'h10, conflict=0, pair_cnt=1.
REQ-029 Contradiction: feed 20'h00001, 20'h80000, 20'h00001 -> cell0 of the 2nd pair gives k=1 with v=1, which contradicts rule[1]=0.
- Required: conflict=1, FSM=FAULT, rule=8'h10, known=8'h17, pair_cnt=2.
- A subsequent in_valid with 20'h0 SHALL change nothing.
REQ-030 Intra-pair conflict: feed 20'h00000 then 20'h00001 -> conflict=1, known=0, done=0.
REQ-031 Full learning: drive 12 or more consecutive rule-184 generations from a random seed until known=8'hFF -> rule=8'hB8, done=1, conflict=0.
REQ-032 Priority and reset:
- restart together with in_valid -> all outputs 0, state IDLE, sample discarded.
- res pulsed low between two in_valid -> outputs 0 asynchronously; the next sample gives pair_cnt=0.
REQ-033 Saturation: 300 consistent pairs -> pair_cnt=255 and holds at 255.
